m10k_arbiter: RTL and testbench

- Shares one M10K-style single-port memory (`read`/`write`/`address`/`writedata`/`readdata`, registered read data) among NUM_REQ requesters, e.g. the tensor loader, the compute unit's writeback and the host-side loader.
- Round-robin arbitration with a per-requester valid/ready command channel.
- Registered memory command outputs.
- Read data is routed back to the issuing requester via an in-flight tag pipeline matched to the memory read latency.

---
 rtl/m10k_arbiter.sv | 83 ++++++++
 tb/tb_m10k_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/m10k_arbiter.sv
// m10k_arbiter: round-robin sharing of one registered-read M10K port among NUM_REQ requesters.
// Defining M10K_ARB_LOCK_EN adds req_lock so a granted requester can keep priority for a burst.
module m10k_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0]                   req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
`ifdef M10K_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]                   req_lock,
`endif
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_data,
  output logic                                 mem_read,
  output logic                                 mem_write,
  output logic [ADDR_WIDTH-1:0]                mem_address,
  output logic [DATA_WIDTH-1:0]                mem_writedata,
  input  logic [DATA_WIDTH-1:0]                mem_readdata
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] ptr, gidx, cand;
  logic found;
  logic [RD_LATENCY:0] tag_v;
  logic [RD_LATENCY:0][IW-1:0] tag_i;
`ifdef M10K_ARB_LOCK_EN
  logic locked;
`endif
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return (x == IW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction
  always_comb begin
    found = 1'b0;
    gidx = ptr;
    cand = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gidx = cand;
      end
      cand = wrap_inc(cand);
    end
    found = found & reset_n;
  end
  assign req_ready = NUM_REQ'(found) << gidx;
  // tag stage RD_LATENCY lines up with mem_readdata for the read issued RD_LATENCY+1 cycles earlier
  assign rsp_valid = NUM_REQ'(tag_v[RD_LATENCY]) << tag_i[RD_LATENCY];
  assign rsp_data = tag_v[RD_LATENCY] ? mem_readdata : '0;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_address <= '0;
      mem_writedata <= '0;
      tag_v <= '0;
      tag_i <= '0;
`ifdef M10K_ARB_LOCK_EN
      locked <= 1'b0;
`endif
    end else begin
      mem_read <= found & ~req_write[gidx];
      mem_write <= found & req_write[gidx];
      if (found) mem_address <= req_addr[gidx];
      if (found && req_write[gidx]) mem_writedata <= req_wdata[gidx];
      tag_v <= {tag_v[RD_LATENCY-1:0], found & ~req_write[gidx]};
      tag_i <= {tag_i[RD_LATENCY-1:0], gidx};
`ifdef M10K_ARB_LOCK_EN
      locked <= found & req_lock[gidx];
      if (found) ptr <= req_lock[gidx] ? gidx : wrap_inc(gidx);
      else if (locked) ptr <= wrap_inc(ptr);
`else
      if (found) ptr <= wrap_inc(gidx);
`endif
    end
  end
endmodule

// File: tb/tb_m10k_arbiter.sv
// tb_m10k_arbiter: drives two arbiters (read latency 1 and 3) with shared stimulus and
// checks them against a transaction-level round-robin model with a scheduled response table.
module tb_m10k_arbiter;
  localparam int N = 3, AW = 8, DW = 32;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;
  logic [N-1:0] req_valid, req_write;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
`ifdef M10K_ARB_LOCK_EN
  logic [N-1:0] req_lock;
  bit pl [N];
  bit locked;
`endif
  logic [N-1:0] ready1, ready3, rsp_v1, rsp_v3;
  logic [DW-1:0] rsp_d1, rsp_d3, rdata1, rdata3, wd1, wd3;
  logic rd1, wr1, rd3, wr3;
  logic [AW-1:0] ad1, ad3;
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem3 [256];
  logic [DW-1:0] pipe3 [3];
  logic [DW-1:0] ref_mem [256];
  m10k_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef M10K_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(ready1), .rsp_valid(rsp_v1), .rsp_data(rsp_d1), .mem_read(rd1), .mem_write(wr1),
    .mem_address(ad1), .mem_writedata(wd1), .mem_readdata(rdata1));
  m10k_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef M10K_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(ready3), .rsp_valid(rsp_v3), .rsp_data(rsp_d3), .mem_read(rd3), .mem_write(wr3),
    .mem_address(ad3), .mem_writedata(wd3), .mem_readdata(rdata3));
  always @(posedge clock) begin
    if (wr1) mem1[ad1] <= wd1;
    if (rd1) rdata1 <= mem1[ad1];
    if (wr3) mem3[ad3] <= wd3;
    if (rd3) pipe3[0] <= mem3[ad3];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rdata3 = pipe3[2];
  int n_cmp = 0, n_bad = 0, cyc = 0, ptr = 0;
  bit pv [N];
  bit pw [N];
  logic [AW-1:0] pa [N];
  logic [DW-1:0] pd [N];
  bit exp_rd, exp_wr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;
  bit ev [2][8];
  int ei [2][8];
  logic [DW-1:0] ed [2][8];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic arm(input int r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pv[r] = 1'b1;
    pw[r] = w;
    pa[r] = a;
    pd[r] = d;
  endtask
  task automatic step(input bit rst);
    int g, s;
    @(negedge clock);
    reset_n = !rst;
    for (int r = 0; r < N; r++) begin
      req_valid[r] = pv[r];
      req_write[r] = pw[r];
      req_addr[r] = pa[r];
      req_wdata[r] = pd[r];
`ifdef M10K_ARB_LOCK_EN
      req_lock[r] = pl[r];
`endif
    end
    #1;
    g = -1;
    if (!rst) for (int i = 0; i < N; i++) if (g < 0 && pv[(ptr + i) % N]) g = (ptr + i) % N;
    check("ready_l1", 64'(ready1), g < 0 ? 64'd0 : 64'd1 << g);
    check("ready_l3", 64'(ready3), g < 0 ? 64'd0 : 64'd1 << g);
    check("mem_read", {rd3, rd1}, {exp_rd, exp_rd});
    check("mem_write", {wr3, wr1}, {exp_wr, exp_wr});
    check("mem_address", {ad3, ad1}, {exp_addr, exp_addr});
    if (exp_wr) check("mem_writedata", {wd3, wd1}, {exp_wd, exp_wd});
    s = cyc % 8;
    check("rsp_valid_l1", 64'(rsp_v1), ev[0][s] ? 64'd1 << ei[0][s] : 64'd0);
    if (ev[0][s]) check("rsp_data_l1", 64'(rsp_d1), 64'(ed[0][s]));
    check("rsp_valid_l3", 64'(rsp_v3), ev[1][s] ? 64'd1 << ei[1][s] : 64'd0);
    if (ev[1][s]) check("rsp_data_l3", 64'(rsp_d3), 64'(ed[1][s]));
    ev[0][s] = 1'b0;
    ev[1][s] = 1'b0;
    if (rst) begin
      ptr = 0;
      exp_rd = 1'b0;
      exp_wr = 1'b0;
      exp_addr = '0;
      exp_wd = '0;
      for (int l = 0; l < 2; l++) for (int k = 0; k < 8; k++) ev[l][k] = 1'b0;
`ifdef M10K_ARB_LOCK_EN
      locked = 1'b0;
`endif
    end else begin
      exp_rd = g >= 0 && !pw[g];
      exp_wr = g >= 0 && pw[g];
      if (g >= 0) begin
        exp_addr = pa[g];
        if (pw[g]) begin
          exp_wd = pd[g];
          ref_mem[pa[g]] = pd[g];
        end else begin
          ev[0][(cyc + 2) % 8] = 1'b1;
          ei[0][(cyc + 2) % 8] = g;
          ed[0][(cyc + 2) % 8] = ref_mem[pa[g]];
          ev[1][(cyc + 4) % 8] = 1'b1;
          ei[1][(cyc + 4) % 8] = g;
          ed[1][(cyc + 4) % 8] = ref_mem[pa[g]];
        end
      end
`ifdef M10K_ARB_LOCK_EN
      if (g >= 0) begin
        ptr = pl[g] ? g : (g + 1) % N;
        locked = pl[g];
      end else if (locked) begin
        ptr = (ptr + 1) % N;
        locked = 1'b0;
      end
`else
      if (g >= 0) ptr = (g + 1) % N;
`endif
      if (g >= 0) pv[g] = 1'b0;
    end
    @(posedge clock);
    cyc++;
  endtask
  initial begin
    for (int a = 0; a < 256; a++) begin
      mem1[a] <= DW'(a + 6);
      mem3[a] <= DW'(a + 6);
      ref_mem[a] = DW'(a + 6);
    end
    reset_n = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
`ifdef M10K_ARB_LOCK_EN
    req_lock = '0;
`endif
    repeat (2) @(posedge clock);
    step(1'b1);
    arm(0, 1'b0, 8'h0A, '0);
    repeat (3) step(1'b0);
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < N; r++) if (!pv[r]) arm(r, 1'b0, AW'(r + 1), '0);
      step(1'b0);
    end
    for (int r = 0; r < N; r++) pv[r] = 1'b0;
    repeat (5) step(1'b0);
    arm(1, 1'b1, 8'h05, 32'hDEAD_BEEF);
    step(1'b0);
    arm(2, 1'b0, 8'h05, '0);
    repeat (6) step(1'b0);
    for (int k = 0; k < 4; k++) begin
      arm((k % 2) * 2, 1'b0, AW'(8'h20 + k), '0);
      step(1'b0);
    end
    repeat (5) step(1'b0);
    arm(0, 1'b0, 8'h33, '0);
    step(1'b0);
    step(1'b1);
    for (int r = 0; r < N; r++) arm(r, 1'b0, AW'(8'h40 + r), '0);
    repeat (8) step(1'b0);
`ifdef M10K_ARB_LOCK_EN
    arm(0, 1'b0, 8'h50, '0);
    step(1'b0);
    arm(0, 1'b0, 8'h51, '0);
    arm(1, 1'b0, 8'h60, '0);
    pl[1] = 1'b1;
    step(1'b0);
    arm(1, 1'b0, 8'h61, '0);
    step(1'b0);
    arm(1, 1'b0, 8'h62, '0);
    pl[1] = 1'b0;
    repeat (6) step(1'b0);
`endif
    for (int k = 0; k < 400; k++) begin
      for (int r = 0; r < N; r++) if (!pv[r] && $urandom_range(1, 0) == 1) begin
        arm(r, $urandom_range(1, 0) == 1, AW'($urandom_range(15, 0)), DW'($urandom));
`ifdef M10K_ARB_LOCK_EN
        pl[r] = $urandom_range(2, 0) == 0;
`endif
      end
      step($urandom_range(49, 0) == 0);
    end
    for (int r = 0; r < N; r++) pv[r] = 1'b0;
    repeat (6) step(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
